slc3_datapath_param: RTL and testbench
======================================

Name: slc3_datapath_param

Overview:
Parametrised SLC-3 datapath with an internal general-purpose register file, a single-driver data bus, and PC/MAR/MDR/IR/CC/BEN/LED state.
- Data width, register count and LED width are generalised.
- Adds a wait-state memory handshake for MDR reads and proper one-hot condition codes.
- Sits between the ISDU control FSM, the ALU/address adders and the memory/IO interface.

Parameters:
WIDTH, 16, data/bus width; must be >= 16 (IR field positions fixed at LC-3 bits)
NUM_REGS, 8, general registers; power of 2, 2..8; RAW = $clog2(NUM_REGS)
LED_W, 12, LED register width; LED_W <= WIDTH
MEM_TIMEOUT, 15, max wait cycles for Mem_Rdy before abort

Ports:
Clk  in  1  clock, rising edge
Reset_al  in  1  asynchronous active-low reset
GatePC, GateMDR, GateMARMUX, GateALU  in  1 each  bus drive enables
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables
PCMUX  in  2  0: PC+1, 1: MARMUX_In, 2: Bus, 3: hold
DRMUX, SR1MUX  in  1 each  register-select muxes
MIO_EN  in  1  MDR source: 1 = memory, 0 = bus
MDR_In  in  WIDTH  memory read data
Mem_Rdy  in  1  memory read data valid
MARMUX_In, ALU_In  in  WIDTH  address-adder and ALU results
Bus  out  WIDTH  internal data bus
PC, MAR, MDR, IR  out  WIDTH  architectural registers
SR1_Out, SR2_Out  out  WIDTH  register-file read ports
NZP  out  3  condition codes {n,z,p}
BEN  out  1  branch enable
LED  out  LED_W  LED register
Mem_Req  out  1  memory read request
Mem_Busy  out  1  read outstanding
Mem_Err  out  1  one-cycle pulse on timeout
Bus_Err  out  1  sticky bus contention flag

Behaviour:
- Reset (Reset_al low, asynchronous): all registers and register-file entries are 0. NZP = 3'b010. BEN, LED, Mem_Req, Mem_Busy, Mem_Err and Bus_Err are 0. FSM goes to IDLE. Reset mid-read aborts the read and drops Mem_Req.
- Bus: combinational; priority PC > MDR > MARMUX_In > ALU_In; 0 when no gate is asserted.
- Register-file select:
  - DR = IR[11:9] truncated to RAW bits, or NUM_REGS-1 when DRMUX = 1.
  - SR1 = IR[11:9] when SR1MUX = 1, else IR[8:6].
  - SR2 = IR[2:0].
  - All indices are truncated to RAW bits.
- Register-file read ports: combinational. LD_REG writes Bus to DR on the clock edge. Same-cycle read of DR returns the old value (no bypass).
- LD_MAR and LD_IR capture Bus on the edge.
- LD_PC selects the next PC per PCMUX:
  - PCMUX=0: PC + 1, wrapping modulo 2^WIDTH (all-ones -> 0).
  - PCMUX=3: PC holds.
- LD_CC derives exactly one NZP bit from Bus, treated as signed: n = Bus[WIDTH-1]; z = (Bus == 0); p = otherwise.
- LD_BEN: BEN <= (IR[11]&n) | (IR[10]&z) | (IR[9]&p), using the registered NZP value from before any same-cycle LD_CC.
- LD_LED: LED <= IR[LED_W-1:0].
- MDR with MIO_EN=0: LD_MDR loads Bus on the edge.
- MDR with MIO_EN=1: handled by the read FSM (states IDLE, WAIT).
  - IDLE & LD_MDR & MIO_EN -> WAIT. Mem_Req and Mem_Busy go high starting the next cycle; wait counter cleared.
  - WAIT & Mem_Rdy -> IDLE. MDR <= MDR_In on that edge; Mem_Req and Mem_Busy drop the following cycle. Minimum latency is 2 edges from the request.
  - WAIT & !Mem_Rdy: counter increments. When counter == MEM_TIMEOUT -> IDLE, MDR unchanged, Mem_Err pulses high for 1 cycle.
  - Any LD_MDR while in WAIT is ignored, whatever the MIO_EN value.
- Simultaneous loads: all LD_* signals are independent and may coincide. LD_REG and LD_CC in the same cycle both see the same Bus value.

Optional Feature:
SLC3_BUS_CHECK_EN
- Defined: Bus_Err is set on any edge where two or more Gate* inputs are high. It stays set until reset. Bus priority is unchanged.
- Undefined: Bus_Err is tied to 0 and no contention logic is built.

Test Plan:
1. Reset with Reset_al low mid-cycle, Clk stopped -> all outputs 0 immediately; NZP=010.
2. GateALU with ALU_In=16'h8000, LD_CC -> NZP=100. Then ALU_In=0 -> NZP=010. Then 16'h0005 -> NZP=001; only one NZP bit is ever set.
3. IR=16'h0E00 (nzp=111), LD_BEN after NZP=001 -> BEN=1. IR=16'h0800, LD_BEN -> BEN=0.
4. GateALU=1, ALU_In=16'h1234, DRMUX=1, LD_REG; then SR1MUX=0, IR[8:6]=7 -> SR1_Out=16'h1234. Separately, PC=16'hFFFF with LD_PC and PCMUX=0 -> PC=16'h0000.
5. Memory read, LD_MDR+MIO_EN, Mem_Rdy held low 3 cycles then high with MDR_In=16'hBEEF -> Mem_Req high for 4 cycles, MDR=16'hBEEF, a second LD_MDR during WAIT is ignored. With Mem_Rdy held low -> Mem_Err pulses after 15 wait cycles and MDR is unchanged.
6. With SLC3_BUS_CHECK_EN defined, GatePC and GateALU high together -> Bus=PC, Bus_Err=1 sticky until reset. Without the macro -> Bus_Err stays 0.

Source files
------------

// File: rtl/slc3_datapath_param.sv
// Parametrised SLC-3 datapath: bus mux, register file, PC/MAR/MDR/IR/CC/BEN/LED and a wait-state MDR read FSM.
// Optional macro SLC3_BUS_CHECK_EN builds a sticky bus-contention detector on Bus_Err.
module slc3_datapath_param #(
   parameter int WIDTH       = 16,
   parameter int NUM_REGS    = 8,
   parameter int LED_W       = 12,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             Clk,
   input  logic             Reset_al,
   input  logic             GatePC,
   input  logic             GateMDR,
   input  logic             GateMARMUX,
   input  logic             GateALU,
   input  logic             LD_MAR,
   input  logic             LD_MDR,
   input  logic             LD_IR,
   input  logic             LD_BEN,
   input  logic             LD_CC,
   input  logic             LD_REG,
   input  logic             LD_PC,
   input  logic             LD_LED,
   input  logic [1:0]       PCMUX,
   input  logic             DRMUX,
   input  logic             SR1MUX,
   input  logic             MIO_EN,
   input  logic [WIDTH-1:0] MDR_In,
   input  logic             Mem_Rdy,
   input  logic [WIDTH-1:0] MARMUX_In,
   input  logic [WIDTH-1:0] ALU_In,
   output logic [WIDTH-1:0] Bus,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] MAR,
   output logic [WIDTH-1:0] MDR,
   output logic [WIDTH-1:0] IR,
   output logic [WIDTH-1:0] SR1_Out,
   output logic [WIDTH-1:0] SR2_Out,
   output logic [2:0]       NZP,
   output logic             BEN,
   output logic [LED_W-1:0] LED,
   output logic             Mem_Req,
   output logic             Mem_Busy,
   output logic             Mem_Err,
   output logic             Bus_Err
);

   // state  | meaning
   // S_IDLE | no memory read outstanding; LD_MDR with MIO_EN=0 loads MDR from Bus
   // S_WAIT | read outstanding; Mem_Req/Mem_Busy high, waiting for Mem_Rdy or timeout

   localparam int RAW = $clog2(NUM_REGS);
   localparam int CW  = $clog2(MEM_TIMEOUT + 1);
   localparam logic [RAW-1:0] LAST_REG  = RAW'(NUM_REGS - 1);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(MEM_TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_WAIT} mem_state_t;

   mem_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_d;
   logic             mdr_from_bus;
   logic             mdr_from_mem;
   logic [WIDTH-1:0] regs [NUM_REGS];
   logic [RAW-1:0]   dr_sel, sr1_sel, sr2_sel;
   logic [2:0]       nzp_new;
   logic [WIDTH-1:0] pc_next;

   always_comb begin
      Bus = '0;
      if (GatePC)          Bus = PC;
      else if (GateMDR)    Bus = MDR;
      else if (GateMARMUX) Bus = MARMUX_In;
      else if (GateALU)    Bus = ALU_In;
   end

   assign dr_sel  = DRMUX  ? LAST_REG : IR[9 +: RAW];
   assign sr1_sel = SR1MUX ? IR[9 +: RAW] : IR[6 +: RAW];
   assign sr2_sel = IR[0 +: RAW];
   assign SR1_Out = regs[sr1_sel];
   assign SR2_Out = regs[sr2_sel];

   always_ff @(posedge Clk or negedge Reset_al) begin
      if (!Reset_al) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (LD_REG) begin
         regs[dr_sel] <= Bus;
      end
   end

   always_comb begin
      nzp_new = 3'b001;
      if (Bus[WIDTH-1])   nzp_new = 3'b100;
      else if (Bus == '0) nzp_new = 3'b010;
   end

   always_comb begin
      case (PCMUX)
         2'd0:    pc_next = PC + WIDTH'(1);
         2'd1:    pc_next = MARMUX_In;
         2'd2:    pc_next = Bus;
         default: pc_next = PC;
      endcase
   end

   // BEN deliberately reads the registered NZP, so a same-cycle LD_CC does not feed through
   always_ff @(posedge Clk or negedge Reset_al) begin
      if (!Reset_al) begin
         PC  <= '0;
         MAR <= '0;
         IR  <= '0;
         NZP <= 3'b010;
         BEN <= 1'b0;
         LED <= '0;
      end else begin
         if (LD_PC)  PC  <= pc_next;
         if (LD_MAR) MAR <= Bus;
         if (LD_IR)  IR  <= Bus;
         if (LD_CC)  NZP <= nzp_new;
         if (LD_BEN) BEN <= (IR[11] & NZP[2]) | (IR[10] & NZP[1]) | (IR[9] & NZP[0]);
         if (LD_LED) LED <= IR[LED_W-1:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_d        = 1'b0;
      mdr_from_bus = 1'b0;
      mdr_from_mem = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (LD_MDR) begin
               if (MIO_EN) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end else begin
                  mdr_from_bus = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (Mem_Rdy) begin
               state_d      = S_IDLE;
               mdr_from_mem = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_al) begin
      if (!Reset_al) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         Mem_Err <= 1'b0;
         MDR     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         Mem_Err <= err_d;
         if (mdr_from_mem)      MDR <= MDR_In;
         else if (mdr_from_bus) MDR <= Bus;
      end
   end

   assign Mem_Req  = (state_q == S_WAIT);
   assign Mem_Busy = (state_q == S_WAIT);

`ifdef SLC3_BUS_CHECK_EN
   logic contention;
   assign contention = (GatePC & (GateMDR | GateMARMUX | GateALU)) |
                       (GateMDR & (GateMARMUX | GateALU)) |
                       (GateMARMUX & GateALU);

   always_ff @(posedge Clk or negedge Reset_al) begin
      if (!Reset_al)       Bus_Err <= 1'b0;
      else if (contention) Bus_Err <= 1'b1;
   end
`else
   assign Bus_Err = 1'b0;
`endif

endmodule

// File: tb/tb_slc3_datapath_param.sv
// Directed self-checking bench for slc3_datapath_param (default parameters).
module tb_slc3_datapath_param;

   logic        Clk, Reset_al, run;
   logic        GatePC, GateMDR, GateMARMUX, GateALU;
   logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic [1:0]  PCMUX;
   logic        DRMUX, SR1MUX, MIO_EN, Mem_Rdy;
   logic [15:0] MDR_In, MARMUX_In, ALU_In;
   logic [15:0] Bus, PC, MAR, MDR, IR, SR1_Out, SR2_Out;
   logic [2:0]  NZP;
   logic        BEN, Mem_Req, Mem_Busy, Mem_Err, Bus_Err;
   logic [11:0] LED;

   int n_checks = 0;
   int n_err    = 0;
   int req_cyc, err_n, err_at;

`ifdef SLC3_BUS_CHECK_EN
   localparam logic EXP_BE = 1'b1;
`else
   localparam logic EXP_BE = 1'b0;
`endif

   slc3_datapath_param dut (
      .Clk(Clk), .Reset_al(Reset_al),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateMARMUX(GateMARMUX), .GateALU(GateALU),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .MIO_EN(MIO_EN),
      .MDR_In(MDR_In), .Mem_Rdy(Mem_Rdy), .MARMUX_In(MARMUX_In), .ALU_In(ALU_In),
      .Bus(Bus), .PC(PC), .MAR(MAR), .MDR(MDR), .IR(IR),
      .SR1_Out(SR1_Out), .SR2_Out(SR2_Out), .NZP(NZP), .BEN(BEN), .LED(LED),
      .Mem_Req(Mem_Req), .Mem_Busy(Mem_Busy), .Mem_Err(Mem_Err), .Bus_Err(Bus_Err)
   );

   initial Clk = 1'b0;
   always #5 if (run) Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_ctl;
      GatePC = 0; GateMDR = 0; GateMARMUX = 0; GateALU = 0;
      LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0;
      LD_CC = 0; LD_REG = 0; LD_PC = 0; LD_LED = 0;
      PCMUX = 2'd3; DRMUX = 0; SR1MUX = 0; MIO_EN = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      run = 0; Reset_al = 1;
      clear_ctl();
      Mem_Rdy = 0; MDR_In = '0; MARMUX_In = '0; ALU_In = '0;

      // async reset with clock stopped
      #2 Reset_al = 0;
      #1;
      chk("rst_pc", 32'(PC), 32'h0);
      chk("rst_mdr", 32'(MDR), 32'h0);
      chk("rst_nzp", 32'(NZP), 32'h2);
      chk("rst_ben", 32'(BEN), 32'h0);
      chk("rst_led", 32'(LED), 32'h0);
      chk("rst_req", 32'(Mem_Req), 32'h0);
      chk("rst_buserr", 32'(Bus_Err), 32'h0);
      chk("rst_bus", 32'(Bus), 32'h0);
      #3 Reset_al = 1;
      #2 run = 1;

      // condition codes
      GateALU = 1; LD_CC = 1; ALU_In = 16'h8000; tick();
      chk("nzp_neg", 32'(NZP), 32'h4);
      ALU_In = 16'h0000; tick();
      chk("nzp_zero", 32'(NZP), 32'h2);
      ALU_In = 16'h0005; tick();
      chk("nzp_pos", 32'(NZP), 32'h1);

      // branch enable
      LD_CC = 0; ALU_In = 16'h0E00; LD_IR = 1; tick();
      chk("ir_load", 32'(IR), 32'h0E00);
      LD_IR = 0; LD_BEN = 1; tick();
      chk("ben_p", 32'(BEN), 32'h1);
      LD_BEN = 0; ALU_In = 16'h0800; LD_IR = 1; tick();
      LD_IR = 0; LD_BEN = 1; LD_CC = 1; ALU_In = 16'h8000; tick();
      chk("ben_old_nzp", 32'(BEN), 32'h0);
      chk("nzp_neg2", 32'(NZP), 32'h4);
      LD_CC = 0; tick();
      chk("ben_n", 32'(BEN), 32'h1);
      LD_BEN = 0;

      // LED
      ALU_In = 16'hFABC; LD_IR = 1; tick();
      LD_IR = 0; LD_LED = 1; tick();
      chk("led", 32'(LED), 32'hABC);
      LD_LED = 0;

      // register file
      ALU_In = 16'h1234; DRMUX = 1; LD_REG = 1; tick();
      LD_REG = 0; DRMUX = 0; ALU_In = 16'h01C0; LD_IR = 1; tick();
      LD_IR = 0; SR1MUX = 0; #1;
      chk("sr1_r7", 32'(SR1_Out), 32'h1234);
      chk("sr2_r0", 32'(SR2_Out), 32'h0);
      SR1MUX = 1; ALU_In = 16'h5555; LD_REG = 1; LD_CC = 1; #1;
      chk("sr1_no_bypass", 32'(SR1_Out), 32'h0);
      tick();
      chk("sr1_written", 32'(SR1_Out), 32'h5555);
      chk("nzp_with_reg", 32'(NZP), 32'h1);
      LD_REG = 0; LD_CC = 0;

      // PC
      ALU_In = 16'hFFFF; LD_PC = 1; PCMUX = 2'd2; tick();
      chk("pc_bus", 32'(PC), 32'hFFFF);
      PCMUX = 2'd0; tick();
      chk("pc_wrap", 32'(PC), 32'h0000);
      tick();
      chk("pc_inc", 32'(PC), 32'h0001);
      MARMUX_In = 16'h3000; PCMUX = 2'd1; tick();
      chk("pc_marmux", 32'(PC), 32'h3000);
      PCMUX = 2'd3; tick();
      chk("pc_hold", 32'(PC), 32'h3000);
      LD_PC = 0;

      // MAR and MDR from bus
      GateALU = 0; GateMARMUX = 1; LD_MAR = 1; tick();
      chk("mar", 32'(MAR), 32'h3000);
      LD_MAR = 0; GateMARMUX = 0; GateALU = 1; ALU_In = 16'h00AA;
      LD_MDR = 1; MIO_EN = 0; tick();
      chk("mdr_bus", 32'(MDR), 32'h00AA);
      LD_MDR = 0;

      // bus priority
      GatePC = 1; #1;
      chk("bus_pc_over_alu", 32'(Bus), 32'h3000);
      GatePC = 0; GateALU = 0; GateMDR = 1; GateMARMUX = 1; MARMUX_In = 16'h4321; #1;
      chk("bus_mdr_over_mar", 32'(Bus), 32'h00AA);
      GateMDR = 0; #1;
      chk("bus_marmux", 32'(Bus), 32'h4321);
      GateMARMUX = 0; #1;
      chk("bus_idle", 32'(Bus), 32'h0);

      // contention
      GatePC = 1; GateALU = 1; tick();
      chk("bus_err", 32'(Bus_Err), 32'(EXP_BE));
      GatePC = 0; tick();
      chk("bus_err_sticky", 32'(Bus_Err), 32'(EXP_BE));

      // memory read with 3 wait cycles, second LD_MDR ignored
      ALU_In = 16'h1111; MDR_In = 16'hBEEF; Mem_Rdy = 0;
      LD_MDR = 1; MIO_EN = 1; tick();
      chk("mem_busy", 32'(Mem_Busy), 32'h1);
      LD_MDR = 0;
      req_cyc = 0;
      for (int i = 0; i < 6; i++) begin
         if (Mem_Req) req_cyc++;
         Mem_Rdy = (i == 3);
         LD_MDR  = (i == 1);
         MIO_EN  = 0;
         tick();
         if (i == 1) chk("mdr_ld_ignored", 32'(MDR), 32'h00AA);
      end
      LD_MDR = 0; Mem_Rdy = 0;
      chk("mdr_mem", 32'(MDR), 32'hBEEF);
      chk("req_cycles", 32'(req_cyc), 32'd4);
      chk("req_dropped", 32'(Mem_Req), 32'h0);
      chk("no_err", 32'(Mem_Err), 32'h0);

      // minimum latency read
      MDR_In = 16'hC0DE; LD_MDR = 1; MIO_EN = 1; tick();
      LD_MDR = 0; Mem_Rdy = 1; tick();
      Mem_Rdy = 0;
      chk("mdr_fast", 32'(MDR), 32'hC0DE);
      chk("req_fast_drop", 32'(Mem_Req), 32'h0);

      // timeout
      MDR_In = 16'hDEAD; LD_MDR = 1; MIO_EN = 1; tick();
      LD_MDR = 0;
      req_cyc = 0; err_n = 0; err_at = 0;
      for (int i = 1; i <= 20; i++) begin
         if (Mem_Req) req_cyc++;
         if (Mem_Err) begin
            err_n++;
            err_at = i;
         end
         tick();
      end
      chk("to_req_cycles", 32'(req_cyc), 32'd15);
      chk("to_err_pulses", 32'(err_n), 32'd1);
      chk("to_err_cycle", 32'(err_at), 32'd16);
      chk("to_mdr_kept", 32'(MDR), 32'hC0DE);

      // reset mid-read
      LD_MDR = 1; MIO_EN = 1; tick();
      LD_MDR = 0;
      chk("pre_rst_req", 32'(Mem_Req), 32'h1);
      #2 Reset_al = 0;
      #1;
      chk("rst2_req", 32'(Mem_Req), 32'h0);
      chk("rst2_pc", 32'(PC), 32'h0);
      chk("rst2_nzp", 32'(NZP), 32'h2);
      chk("rst2_buserr", 32'(Bus_Err), 32'h0);
      chk("rst2_mdr", 32'(MDR), 32'h0);
      #1 Reset_al = 1;
      tick();
      chk("post_rst_idle", 32'(Mem_Req), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
